// File: rtl/axi_master_arbiter.sv
// Merges the core's ifetch and data AXI4-Lite master ports onto one system bus master.
// One transaction is outstanding at a time; the granted port's channels are forwarded
// combinationally. Write requests from the ifetch port are answered locally with SLVERR.
module axi_master_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  // ifetch port (slave side)
  input  logic        i_ifetch_awvalid,
  output logic        o_ifetch_awready,
  input  logic [31:0] i_ifetch_awaddr,
  input  logic [2:0]  i_ifetch_awprot,
  input  logic        i_ifetch_wvalid,
  output logic        o_ifetch_wready,
  input  logic [31:0] i_ifetch_wdata,
  input  logic [3:0]  i_ifetch_wstrb,
  output logic        o_ifetch_bvalid,
  input  logic        i_ifetch_bready,
  output logic [1:0]  o_ifetch_bresp,
  input  logic        i_ifetch_arvalid,
  output logic        o_ifetch_arready,
  input  logic [31:0] i_ifetch_araddr,
  input  logic [2:0]  i_ifetch_arprot,
  output logic        o_ifetch_rvalid,
  input  logic        i_ifetch_rready,
  output logic [31:0] o_ifetch_rdata,
  output logic [1:0]  o_ifetch_rresp,
  // data port (slave side)
  input  logic        i_data_awvalid,
  output logic        o_data_awready,
  input  logic [31:0] i_data_awaddr,
  input  logic [2:0]  i_data_awprot,
  input  logic        i_data_wvalid,
  output logic        o_data_wready,
  input  logic [31:0] i_data_wdata,
  input  logic [3:0]  i_data_wstrb,
  output logic        o_data_bvalid,
  input  logic        i_data_bready,
  output logic [1:0]  o_data_bresp,
  input  logic        i_data_arvalid,
  output logic        o_data_arready,
  input  logic [31:0] i_data_araddr,
  input  logic [2:0]  i_data_arprot,
  output logic        o_data_rvalid,
  input  logic        i_data_rready,
  output logic [31:0] o_data_rdata,
  output logic [1:0]  o_data_rresp,
  // system bus (master side)
  output logic        o_sys_awvalid,
  input  logic        i_sys_awready,
  output logic [31:0] o_sys_awaddr,
  output logic [2:0]  o_sys_awprot,
  output logic        o_sys_wvalid,
  input  logic        i_sys_wready,
  output logic [31:0] o_sys_wdata,
  output logic [3:0]  o_sys_wstrb,
  input  logic        i_sys_bvalid,
  output logic        o_sys_bready,
  input  logic [1:0]  i_sys_bresp,
  output logic        o_sys_arvalid,
  input  logic        i_sys_arready,
  output logic [31:0] o_sys_araddr,
  output logic [2:0]  o_sys_arprot,
  input  logic        i_sys_rvalid,
  output logic        o_sys_rready,
  input  logic [31:0] i_sys_rdata,
  input  logic [1:0]  i_sys_rresp
);

  typedef enum logic [2:0] {StIdle, StRd, StWr, StWrResp, StWrErr} state_e;

  state_e r_state, w_state_next;
  logic   r_gnt_data;   // 1: data port owns the bus, 0: ifetch port
  logic   r_last_data;  // last completed grant went to the data port
  logic   r_aw_done, r_w_done, r_ar_done;

  logic w_data_rd, w_data_req, w_ifetch_rd, w_ifetch_req, w_pick_data;
  logic w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs, w_wr_both;
  logic w_err_aw_hs, w_err_w_hs, w_err_b_hs;

  // ifetch write payload is never forwarded
  logic w_unused_ifetch;
  assign w_unused_ifetch = ^{i_ifetch_awaddr, i_ifetch_awprot, i_ifetch_wdata, i_ifetch_wstrb};

  assign w_data_rd    = i_data_arvalid;
  assign w_data_req   = i_data_arvalid | i_data_awvalid | i_data_wvalid;
  assign w_ifetch_rd  = i_ifetch_arvalid;
  assign w_ifetch_req = i_ifetch_arvalid | i_ifetch_awvalid | i_ifetch_wvalid;
  // Round-robin tie goes to the port that did not win last time
  assign w_pick_data  = w_data_req & (~w_ifetch_req | DATA_FIRST | ~r_last_data);

  assign w_ar_hs     = o_sys_arvalid & i_sys_arready;
  assign w_r_hs      = i_sys_rvalid & o_sys_rready;
  assign w_aw_hs     = o_sys_awvalid & i_sys_awready;
  assign w_w_hs      = o_sys_wvalid & i_sys_wready;
  assign w_b_hs      = i_sys_bvalid & o_sys_bready;
  assign w_wr_both   = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
  assign w_err_aw_hs = i_ifetch_awvalid & o_ifetch_awready;
  assign w_err_w_hs  = i_ifetch_wvalid & o_ifetch_wready;
  assign w_err_b_hs  = o_ifetch_bvalid & i_ifetch_bready;

  // Payload fields follow the grant; only valid/ready are qualified by state
  assign o_sys_araddr   = r_gnt_data ? i_data_araddr : i_ifetch_araddr;
  assign o_sys_arprot   = r_gnt_data ? i_data_arprot : i_ifetch_arprot;
  assign o_sys_awaddr   = i_data_awaddr;
  assign o_sys_awprot   = i_data_awprot;
  assign o_sys_wdata    = i_data_wdata;
  assign o_sys_wstrb    = i_data_wstrb;
  assign o_data_rdata   = i_sys_rdata;
  assign o_data_rresp   = i_sys_rresp;
  assign o_ifetch_rdata = i_sys_rdata;
  assign o_ifetch_rresp = i_sys_rresp;
  assign o_data_bresp   = i_sys_bresp;
  assign o_ifetch_bresp = 2'b10;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Grant, fairness history and per-channel completion flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt_data  <= 1'b0;
      r_last_data <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_ar_done   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_gnt_data <= w_pick_data;
          r_aw_done  <= 1'b0;
          r_w_done   <= 1'b0;
          r_ar_done  <= 1'b0;
        end
        StRd: begin
          if (w_r_hs) begin
            r_ar_done   <= 1'b0;
            r_last_data <= r_gnt_data;
          end else if (w_ar_hs) begin
            r_ar_done <= 1'b1;
          end
        end
        StWr: begin
          if (w_wr_both) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
          end
        end
        StWrResp: begin
          if (w_b_hs) r_last_data <= 1'b1;
        end
        StWrErr: begin
          if (w_err_b_hs) begin
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_last_data <= 1'b0;
          end else begin
            if (w_err_aw_hs) r_aw_done <= 1'b1;
            if (w_err_w_hs)  r_w_done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state: arbitration in idle, then wait for the closing handshake
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_pick_data)       w_state_next = w_data_rd ? StRd : StWr;
        else if (w_ifetch_req) w_state_next = w_ifetch_rd ? StRd : StWrErr;
      end
      StRd:     if (w_r_hs)     w_state_next = StIdle;
      StWr:     if (w_wr_both)  w_state_next = StWrResp;
      StWrResp: if (w_b_hs)     w_state_next = StIdle;
      StWrErr:  if (w_err_b_hs) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Valid/ready routing for the granted port; everything else held low
  always_comb begin
    o_ifetch_awready = 1'b0;
    o_ifetch_wready  = 1'b0;
    o_ifetch_bvalid  = 1'b0;
    o_ifetch_arready = 1'b0;
    o_ifetch_rvalid  = 1'b0;
    o_data_awready   = 1'b0;
    o_data_wready    = 1'b0;
    o_data_bvalid    = 1'b0;
    o_data_arready   = 1'b0;
    o_data_rvalid    = 1'b0;
    o_sys_awvalid    = 1'b0;
    o_sys_wvalid     = 1'b0;
    o_sys_bready     = 1'b0;
    o_sys_arvalid    = 1'b0;
    o_sys_rready     = 1'b0;
    unique case (r_state)
      StRd: begin
        if (r_gnt_data) begin
          o_sys_arvalid  = i_data_arvalid & ~r_ar_done;
          o_data_arready = i_sys_arready & ~r_ar_done;
          o_data_rvalid  = i_sys_rvalid;
          o_sys_rready   = i_data_rready;
        end else begin
          o_sys_arvalid    = i_ifetch_arvalid & ~r_ar_done;
          o_ifetch_arready = i_sys_arready & ~r_ar_done;
          o_ifetch_rvalid  = i_sys_rvalid;
          o_sys_rready     = i_ifetch_rready;
        end
      end
      StWr: begin
        o_sys_awvalid  = i_data_awvalid & ~r_aw_done;
        o_data_awready = i_sys_awready & ~r_aw_done;
        o_sys_wvalid   = i_data_wvalid & ~r_w_done;
        o_data_wready  = i_sys_wready & ~r_w_done;
      end
      StWrResp: begin
        o_data_bvalid = i_sys_bvalid;
        o_sys_bready  = i_data_bready;
      end
      StWrErr: begin
        o_ifetch_awready = ~r_aw_done;
        o_ifetch_wready  = ~r_w_done;
        o_ifetch_bvalid  = r_aw_done & r_w_done;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter: instance 0 uses fixed data priority, instance 1
// round-robin. Both share all inputs; the variable sel chooses which one is checked.
module tb_axi_master_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        i_ifetch_awvalid, i_ifetch_wvalid, i_ifetch_bready, i_ifetch_arvalid;
  logic        i_ifetch_rready;
  logic [31:0] i_ifetch_awaddr, i_ifetch_wdata, i_ifetch_araddr;
  logic [2:0]  i_ifetch_awprot, i_ifetch_arprot;
  logic [3:0]  i_ifetch_wstrb;
  logic        i_data_awvalid, i_data_wvalid, i_data_bready, i_data_arvalid, i_data_rready;
  logic [31:0] i_data_awaddr, i_data_wdata, i_data_araddr;
  logic [2:0]  i_data_awprot, i_data_arprot;
  logic [3:0]  i_data_wstrb;
  logic        i_sys_awready, i_sys_wready, i_sys_bvalid, i_sys_arready, i_sys_rvalid;
  logic [1:0]  i_sys_bresp, i_sys_rresp;
  logic [31:0] i_sys_rdata;

  logic        o_ifetch_awready [2];
  logic        o_ifetch_wready  [2];
  logic        o_ifetch_bvalid  [2];
  logic [1:0]  o_ifetch_bresp   [2];
  logic        o_ifetch_arready [2];
  logic        o_ifetch_rvalid  [2];
  logic [31:0] o_ifetch_rdata   [2];
  logic [1:0]  o_ifetch_rresp   [2];
  logic        o_data_awready   [2];
  logic        o_data_wready    [2];
  logic        o_data_bvalid    [2];
  logic [1:0]  o_data_bresp     [2];
  logic        o_data_arready   [2];
  logic        o_data_rvalid    [2];
  logic [31:0] o_data_rdata     [2];
  logic [1:0]  o_data_rresp     [2];
  logic        o_sys_awvalid    [2];
  logic [31:0] o_sys_awaddr     [2];
  logic [2:0]  o_sys_awprot     [2];
  logic        o_sys_wvalid     [2];
  logic [31:0] o_sys_wdata      [2];
  logic [3:0]  o_sys_wstrb      [2];
  logic        o_sys_bready     [2];
  logic        o_sys_arvalid    [2];
  logic [31:0] o_sys_araddr     [2];
  logic [2:0]  o_sys_arprot     [2];
  logic        o_sys_rready     [2];

  int n_checks = 0;
  int n_errors = 0;
  int sel = 0;
  int gnt_data_cnt = 0;
  int gnt_ifetch_cnt = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_master_arbiter #(.DATA_FIRST(g == 0)) u_dut (
      .clk              (clk),
      .rst              (rst),
      .i_ifetch_awvalid (i_ifetch_awvalid),
      .o_ifetch_awready (o_ifetch_awready[g]),
      .i_ifetch_awaddr  (i_ifetch_awaddr),
      .i_ifetch_awprot  (i_ifetch_awprot),
      .i_ifetch_wvalid  (i_ifetch_wvalid),
      .o_ifetch_wready  (o_ifetch_wready[g]),
      .i_ifetch_wdata   (i_ifetch_wdata),
      .i_ifetch_wstrb   (i_ifetch_wstrb),
      .o_ifetch_bvalid  (o_ifetch_bvalid[g]),
      .i_ifetch_bready  (i_ifetch_bready),
      .o_ifetch_bresp   (o_ifetch_bresp[g]),
      .i_ifetch_arvalid (i_ifetch_arvalid),
      .o_ifetch_arready (o_ifetch_arready[g]),
      .i_ifetch_araddr  (i_ifetch_araddr),
      .i_ifetch_arprot  (i_ifetch_arprot),
      .o_ifetch_rvalid  (o_ifetch_rvalid[g]),
      .i_ifetch_rready  (i_ifetch_rready),
      .o_ifetch_rdata   (o_ifetch_rdata[g]),
      .o_ifetch_rresp   (o_ifetch_rresp[g]),
      .i_data_awvalid   (i_data_awvalid),
      .o_data_awready   (o_data_awready[g]),
      .i_data_awaddr    (i_data_awaddr),
      .i_data_awprot    (i_data_awprot),
      .i_data_wvalid    (i_data_wvalid),
      .o_data_wready    (o_data_wready[g]),
      .i_data_wdata     (i_data_wdata),
      .i_data_wstrb     (i_data_wstrb),
      .o_data_bvalid    (o_data_bvalid[g]),
      .i_data_bready    (i_data_bready),
      .o_data_bresp     (o_data_bresp[g]),
      .i_data_arvalid   (i_data_arvalid),
      .o_data_arready   (o_data_arready[g]),
      .i_data_araddr    (i_data_araddr),
      .i_data_arprot    (i_data_arprot),
      .o_data_rvalid    (o_data_rvalid[g]),
      .i_data_rready    (i_data_rready),
      .o_data_rdata     (o_data_rdata[g]),
      .o_data_rresp     (o_data_rresp[g]),
      .o_sys_awvalid    (o_sys_awvalid[g]),
      .i_sys_awready    (i_sys_awready),
      .o_sys_awaddr     (o_sys_awaddr[g]),
      .o_sys_awprot     (o_sys_awprot[g]),
      .o_sys_wvalid     (o_sys_wvalid[g]),
      .i_sys_wready     (i_sys_wready),
      .o_sys_wdata      (o_sys_wdata[g]),
      .o_sys_wstrb      (o_sys_wstrb[g]),
      .i_sys_bvalid     (i_sys_bvalid),
      .o_sys_bready     (o_sys_bready[g]),
      .i_sys_bresp      (i_sys_bresp),
      .o_sys_arvalid    (o_sys_arvalid[g]),
      .i_sys_arready    (i_sys_arready),
      .o_sys_araddr     (o_sys_araddr[g]),
      .o_sys_arprot     (o_sys_arprot[g]),
      .i_sys_rvalid     (i_sys_rvalid),
      .o_sys_rready     (o_sys_rready[g]),
      .i_sys_rdata      (i_sys_rdata),
      .i_sys_rresp      (i_sys_rresp)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step to 2 time units after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    i_ifetch_awvalid = 0; i_ifetch_wvalid = 0; i_ifetch_bready = 0; i_ifetch_arvalid = 0;
    i_ifetch_rready  = 0; i_ifetch_awaddr = 0; i_ifetch_wdata = 0; i_ifetch_araddr = 0;
    i_ifetch_awprot  = 0; i_ifetch_arprot = 0; i_ifetch_wstrb = 0;
    i_data_awvalid   = 0; i_data_wvalid = 0; i_data_bready = 0; i_data_arvalid = 0;
    i_data_rready    = 0; i_data_awaddr = 0; i_data_wdata = 0; i_data_araddr = 0;
    i_data_awprot    = 0; i_data_arprot = 0; i_data_wstrb = 0;
    i_sys_awready    = 0; i_sys_wready = 0; i_sys_bvalid = 0; i_sys_arready = 0;
    i_sys_rvalid     = 0; i_sys_bresp = 0; i_sys_rresp = 0; i_sys_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  // One read from an idle arbiter with the request already presented; zero-wait slave
  task automatic rd_txn(input bit exp_data, input logic [31:0] exp_addr,
                        input logic [31:0] rdata, input bit drop);
    tick();
    i_sys_arready = 1'b1;
    #1;
    chk("rd_arvalid", o_sys_arvalid[sel], 1);
    chk("rd_gnt_data", o_data_arready[sel], exp_data);
    chk("rd_gnt_ifetch", o_ifetch_arready[sel], !exp_data);
    chk("rd_araddr", o_sys_araddr[sel], exp_addr);
    if (o_data_arready[sel]) gnt_data_cnt++;
    if (o_ifetch_arready[sel]) gnt_ifetch_cnt++;
    tick();
    if (drop) begin
      if (exp_data) i_data_arvalid = 1'b0;
      else          i_ifetch_arvalid = 1'b0;
    end
    i_sys_rvalid = 1'b1;
    i_sys_rdata  = rdata;
    i_sys_rresp  = 2'b00;
    #1;
    chk("rd_arvalid_drop", o_sys_arvalid[sel], 0);
    chk("rd_arready_drop", o_data_arready[sel] | o_ifetch_arready[sel], 0);
    chk("rd_rvalid_gnt", exp_data ? o_data_rvalid[sel] : o_ifetch_rvalid[sel], 1);
    chk("rd_rvalid_other", exp_data ? o_ifetch_rvalid[sel] : o_data_rvalid[sel], 0);
    chk("rd_rdata", exp_data ? o_data_rdata[sel] : o_ifetch_rdata[sel], rdata);
    chk("rd_rresp", exp_data ? o_data_rresp[sel] : o_ifetch_rresp[sel], 0);
    chk("rd_rready", o_sys_rready[sel], 1);
    tick();
    i_sys_rvalid = 1'b0;
    #1;
    chk("rd_idle_arvalid", o_sys_arvalid[sel], 0);
    chk("rd_idle_arready", o_data_arready[sel] | o_ifetch_arready[sel], 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: requests present, nothing may respond
    rst = 1'b1;
    clear_inputs();
    i_ifetch_arvalid = 1'b1;
    i_sys_arready    = 1'b1;
    i_sys_rvalid     = 1'b1;
    i_ifetch_rready  = 1'b1;
    #12;
    for (int k = 0; k < 2; k++) begin
      sel = k;
      chk("rst_sys_arvalid", o_sys_arvalid[sel], 0);
      chk("rst_ifetch_arready", o_ifetch_arready[sel], 0);
      chk("rst_ifetch_rvalid", o_ifetch_rvalid[sel], 0);
      chk("rst_sys_rready", o_sys_rready[sel], 0);
    end
    sel = 0;
    tick();
    chk("rst_hold_arvalid", o_sys_arvalid[sel], 0);
    clear_inputs();
    rst = 1'b0;

    // Single ifetch read
    i_ifetch_rready  = 1'b1;
    i_data_rready    = 1'b1;
    i_ifetch_arvalid = 1'b1;
    i_ifetch_araddr  = 32'h8000_0000;
    #1;
    chk("idle_no_ready", o_ifetch_arready[sel], 0);
    chk("idle_no_arvalid", o_sys_arvalid[sel], 0);
    rd_txn(1'b0, 32'h8000_0000, 32'h0000_0013, 1'b1);

    // Data write, W accepted two cycles after AW
    i_data_awvalid = 1'b1;
    i_data_awaddr  = 32'h1000_0004;
    i_data_wvalid  = 1'b1;
    i_data_wdata   = 32'hDEAD_BEEF;
    i_data_wstrb   = 4'hF;
    i_sys_awready  = 1'b1;
    i_sys_wready   = 1'b0;
    #1;
    chk("wr_idle_awvalid", o_sys_awvalid[sel], 0);
    tick();
    #1;
    chk("wr_awvalid", o_sys_awvalid[sel], 1);
    chk("wr_awaddr", o_sys_awaddr[sel], 32'h1000_0004);
    chk("wr_awready", o_data_awready[sel], 1);
    chk("wr_wvalid", o_sys_wvalid[sel], 1);
    chk("wr_wready_wait", o_data_wready[sel], 0);
    tick();
    i_data_awvalid = 1'b0;
    #1;
    chk("wr_aw_held_low", o_sys_awvalid[sel], 0);
    chk("wr_awready_low", o_data_awready[sel], 0);
    chk("wr_wvalid_hold", o_sys_wvalid[sel], 1);
    tick();
    i_sys_wready = 1'b1;
    #1;
    chk("wr_wready", o_data_wready[sel], 1);
    chk("wr_wdata", o_sys_wdata[sel], 32'hDEAD_BEEF);
    chk("wr_wstrb", o_sys_wstrb[sel], 4'hF);
    tick();
    i_data_wvalid = 1'b0;
    i_sys_wready  = 1'b0;
    i_sys_bvalid  = 1'b1;
    i_sys_bresp   = 2'b00;
    i_data_bready = 1'b0;
    #1;
    chk("wr_w_low", o_sys_wvalid[sel], 0);
    chk("wr_bvalid", o_data_bvalid[sel], 1);
    chk("wr_bresp", o_data_bresp[sel], 0);
    chk("wr_bready_wait", o_sys_bready[sel], 0);
    tick();
    #1;
    chk("wr_bvalid_hold", o_data_bvalid[sel], 1);
    i_data_bready = 1'b1;
    #1;
    chk("wr_bready", o_sys_bready[sel], 1);
    tick();
    #1;
    chk("wr_idle_bvalid", o_data_bvalid[sel], 0);
    chk("wr_idle_bready", o_sys_bready[sel], 0);
    i_sys_bvalid  = 1'b0;
    i_data_bready = 1'b0;
    i_sys_awready = 1'b0;

    // Simultaneous reads, fixed priority: data first, then ifetch
    i_data_arvalid   = 1'b1;
    i_data_araddr    = 32'h3000_0000;
    i_ifetch_arvalid = 1'b1;
    i_ifetch_araddr  = 32'h8000_0010;
    rd_txn(1'b1, 32'h3000_0000, 32'h0000_0011, 1'b1);
    rd_txn(1'b0, 32'h8000_0010, 32'h0000_0022, 1'b1);

    // ifetch write is refused locally with SLVERR
    i_ifetch_awvalid = 1'b1;
    i_ifetch_awaddr  = 32'h0;
    i_ifetch_wvalid  = 1'b1;
    i_ifetch_wdata   = 32'h1234_5678;
    i_sys_awready    = 1'b1;
    i_sys_wready     = 1'b1;
    #1;
    chk("err_idle_awready", o_ifetch_awready[sel], 0);
    tick();
    #1;
    chk("err_sys_awvalid", o_sys_awvalid[sel], 0);
    chk("err_sys_wvalid", o_sys_wvalid[sel], 0);
    chk("err_awready", o_ifetch_awready[sel], 1);
    chk("err_wready", o_ifetch_wready[sel], 1);
    chk("err_bvalid_early", o_ifetch_bvalid[sel], 0);
    tick();
    i_ifetch_awvalid = 1'b0;
    i_ifetch_wvalid  = 1'b0;
    i_ifetch_bready  = 1'b0;
    #1;
    chk("err_bvalid", o_ifetch_bvalid[sel], 1);
    chk("err_bresp", o_ifetch_bresp[sel], 2'b10);
    chk("err_awready_done", o_ifetch_awready[sel], 0);
    chk("err_sys_idle", o_sys_awvalid[sel], 0);
    tick();
    #1;
    chk("err_bvalid_hold", o_ifetch_bvalid[sel], 1);
    i_ifetch_bready = 1'b1;
    tick();
    i_ifetch_bready = 1'b0;
    #1;
    chk("err_idle_bvalid", o_ifetch_bvalid[sel], 0);
    i_sys_awready = 1'b0;
    i_sys_wready  = 1'b0;

    // Asynchronous reset while R is pending
    i_data_rready  = 1'b0;
    i_data_arvalid = 1'b1;
    i_data_araddr  = 32'h4000_0000;
    i_sys_arready  = 1'b1;
    tick();
    #1;
    chk("rstrd_arvalid", o_sys_arvalid[sel], 1);
    tick();
    i_data_arvalid = 1'b0;
    i_sys_rvalid   = 1'b1;
    #1;
    chk("rstrd_rvalid", o_data_rvalid[sel], 1);
    rst = 1'b1;
    #1;
    chk("rstrd_rvalid_async", o_data_rvalid[sel], 0);
    chk("rstrd_arvalid_async", o_sys_arvalid[sel], 0);
    chk("rstrd_rready_async", o_sys_rready[sel], 0);
    tick();
    rst            = 1'b0;
    i_sys_rvalid   = 1'b0;
    i_data_rready  = 1'b1;
    i_data_arvalid = 1'b1;
    i_data_araddr  = 32'h2000_0000;
    rd_txn(1'b1, 32'h2000_0000, 32'h0000_0077, 1'b1);

    // Round-robin instance from here on
    do_reset();
    sel = 1;
    i_data_rready   = 1'b1;
    i_ifetch_rready = 1'b1;
    i_data_arvalid  = 1'b1;
    i_data_araddr   = 32'h5000_0000;
    rd_txn(1'b1, 32'h5000_0000, 32'h0000_0033, 1'b1);
    // last grant is data, so ifetch wins the tie
    i_data_arvalid   = 1'b1;
    i_data_araddr    = 32'h5000_0004;
    i_ifetch_arvalid = 1'b1;
    i_ifetch_araddr  = 32'h8000_0020;
    rd_txn(1'b0, 32'h8000_0020, 32'h0000_0044, 1'b1);
    rd_txn(1'b1, 32'h5000_0004, 32'h0000_0055, 1'b1);

    // Continuous requests from both ports alternate
    gnt_data_cnt     = 0;
    gnt_ifetch_cnt   = 0;
    i_data_arvalid   = 1'b1;
    i_data_araddr    = 32'h6000_0000;
    i_ifetch_arvalid = 1'b1;
    i_ifetch_araddr  = 32'h8000_0100;
    for (int k = 0; k < 10; k++) begin
      rd_txn((k % 2) == 1, ((k % 2) == 1) ? 32'h6000_0000 : 32'h8000_0100,
             32'hA000_0000 + k, 1'b0);
    end
    chk("rr_data_grants", gnt_data_cnt, 5);
    chk("rr_ifetch_grants", gnt_ifetch_cnt, 5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
